// File: rtl/kgp_isa_pkg.sv
// Shared KGP-RISC encoding definitions: instruction formats, field positions and
// the loader FSM states used by the encoder/loader slice.
package kgp_isa_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FULL = 2'b10
  } ld_state_e;

  // Field positions, identical to those the decoder slices out.
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RA1_MSB   = 25;
  localparam int RA1_LSB   = 21;
  localparam int RA2_MSB   = 20;
  localparam int RA2_LSB   = 16;
  localparam int SHAMT_MSB = 15;
  localparam int SHAMT_LSB = 11;
  localparam int EXT_MSB   = 10;
  localparam int EXT_LSB   = 0;
  localparam int IMM_MSB   = 20;
  localparam int IMM_LSB   = 0;
  localparam int OFF_MSB   = 25;
  localparam int OFF_LSB   = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic               bad_fmt;
    logic               imm_ovf;
  } pack_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields plus a format tag become one 32-bit
// instruction word, with flags for a reserved format or an unrepresentable immediate.
module instr_pack
  import kgp_isa_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  reg_addr_1,
  input  logic [4:0]  reg_addr_2,
  input  logic [4:0]  shift_amount,
  input  logic [10:0] opcode_ext,
  input  logic [21:0] immediate_const,
  input  logic [25:0] offset,
  output pack_t       result
);

  always_comb begin
    result = '0;
    result.word[OPC_MSB:OPC_LSB] = opcode;
    case (fmt_e'(fmt))
      FMT_R: begin
        result.word[RA1_MSB:RA1_LSB]     = reg_addr_1;
        result.word[RA2_MSB:RA2_LSB]     = reg_addr_2;
        result.word[SHAMT_MSB:SHAMT_LSB] = shift_amount;
        result.word[EXT_MSB:EXT_LSB]     = opcode_ext;
      end
      FMT_I: begin
        result.word[RA1_MSB:RA1_LSB] = reg_addr_1;
        result.word[IMM_MSB:IMM_LSB] = immediate_const[20:0];
        // The encoding holds 21 bits; a 22-bit value only fits if bit 21 is a sign copy.
        result.imm_ovf = immediate_const[21] ^ immediate_const[20];
      end
      FMT_J: begin
        result.word[OFF_MSB:OFF_LSB] = offset;
      end
      default: begin
        result.word    = '0;
        result.bad_fmt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Packs decoded instruction fields and streams the words into imem at consecutive
// word addresses through a single output register with write backpressure.
module instruction_encoder_loader
  import kgp_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        reg_addr_1,
  input  logic [4:0]        reg_addr_2,
  input  logic [4:0]        shift_amount,
  input  logic [10:0]       opcode_ext,
  input  logic [21:0]       immediate_const,
  input  logic [25:0]       offset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              loading,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        state
);

  // Handshakes: a bundle moves when in_valid & in_ready on a rising edge; a write
  // commits when imem_we & imem_ready, and imem_addr/imem_wdata hold until then.

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  ld_state_e          state_q;
  logic               out_valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] wdata_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  pack_t              packed_bundle;
  logic               accept;
  logic               commit;
  logic               last_commit;
  logic [CNT_W:0]     occupancy;

  instr_pack u_pack (
    .fmt             (fmt),
    .opcode          (opcode),
    .reg_addr_1      (reg_addr_1),
    .reg_addr_2      (reg_addr_2),
    .shift_amount    (shift_amount),
    .opcode_ext      (opcode_ext),
    .immediate_const (immediate_const),
    .offset          (offset),
    .result          (packed_bundle)
  );

  // Committed words plus the one waiting in the output register.
  assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, out_valid_q};
  assign in_ready    = (state_q == ST_LOAD) & ~start & (~out_valid_q | imem_ready)
                       & (occupancy < DEPTH_C);
  assign accept      = in_valid & in_ready;
  assign commit      = out_valid_q & imem_ready;
  assign last_commit = commit & (({1'b0, count_q} + (CNT_W + 1)'(1)) == DEPTH_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else if (start) begin
      state_q     <= ST_LOAD;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (commit) begin
        count_q <= count_q + CNT_W'(1);
        // Hold the address on the final commit so it never wraps within a load.
        if (!last_commit) addr_q <= addr_q + ADDR_W'(1);
      end
      if (last_commit) state_q <= ST_FULL;
      if (accept) begin
        if (packed_bundle.bad_fmt) begin
          err_q <= 1'b1;
          if (commit) out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= 1'b1;
          wdata_q     <= packed_bundle.word;
          if (packed_bundle.imm_ovf) err_q <= 1'b1;
        end
      end else if (commit) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign imem_we    = out_valid_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign loading    = (state_q == ST_LOAD);
  assign full       = (state_q == ST_FULL);
  assign err        = err_q;
  assign word_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: a table of single-bundle loads
// plus hand-written sequences for throughput, backpressure, errors, full and reset.
module tb_instruction_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int EW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              imem_ready = 1'b0;
  logic [1:0]        fmt = '0;
  logic [5:0]        opcode = '0;
  logic [4:0]        reg_addr_1 = '0;
  logic [4:0]        reg_addr_2 = '0;
  logic [4:0]        shift_amount = '0;
  logic [10:0]       opcode_ext = '0;
  logic [21:0]       immediate_const = '0;
  logic [25:0]       offset = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              loading;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [1:0]        state;

  instruction_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .fmt             (fmt),
    .opcode          (opcode),
    .reg_addr_1      (reg_addr_1),
    .reg_addr_2      (reg_addr_2),
    .shift_amount    (shift_amount),
    .opcode_ext      (opcode_ext),
    .immediate_const (immediate_const),
    .offset          (offset),
    .imem_we         (imem_we),
    .imem_addr       (imem_addr),
    .imem_wdata      (imem_wdata),
    .imem_ready      (imem_ready),
    .loading         (loading),
    .full            (full),
    .err             (err),
    .word_count      (word_count),
    .state           (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     mon_e;
  logic [ADDR_W-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && imem_we && imem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e[EW-1:32]));
        check("write_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] word);
    exp_q.push_back({exp_addr, word});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic set_bundle(input logic [1:0] f, input logic [5:0] op, input logic [4:0] ra1,
                            input logic [4:0] ra2, input logic [4:0] sh, input logic [10:0] ext,
                            input logic [21:0] imm, input logic [25:0] off);
    fmt = f; opcode = op; reg_addr_1 = ra1; reg_addr_2 = ra2;
    shift_amount = sh; opcode_ext = ext; immediate_const = imm; offset = off;
  endtask

  // Holds in_valid until the bundle is taken; returns just after the accept edge.
  task automatic send();
    int waited;
    logic got;
    waited = 0;
    got = 1'b0;
    in_valid = 1'b1;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      waited++;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  ra1, ra2, sh;
    logic [10:0] ext;
    logic [21:0] imm;
    logic [25:0] off;
    logic [31:0] word;
    logic        wr;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b00, 6'h3F, 5'd31, 5'd0, 5'd31, 11'h7FF, 22'h3FFFFF, 26'h3FFFFFF, 32'hFFE0FFFF, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 6'h08, 5'd3, 5'd9, 5'd9, 11'h555, 22'h000ABC, 26'h1234567, 32'h20600ABC, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 6'h09, 5'd0, 5'd0, 5'd0, 11'h000, 22'h3FFFFF, 26'h0000000, 32'h241FFFFF, 1'b1, 1'b0};
    vecs[3] = '{2'b01, 6'h01, 5'd1, 5'd0, 5'd0, 11'h000, 22'h100000, 26'h0000000, 32'h04300000, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 6'h3E, 5'd17, 5'd5, 5'd5, 11'h0AA, 22'h155555, 26'h3FFFFFF, 32'hFBFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 6'h15, 5'd2, 5'd2, 5'd2, 11'h002, 22'h000002, 26'h0000002, 32'h00000000, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 6'h00, 5'd0, 5'd0, 5'd0, 11'h000, 22'h000000, 26'h0000001, 32'h00000001, 1'b1, 1'b0};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Example R word: 0x10221867 at addr 0 one cycle after accept.
    do_start();
    imem_ready = 1'b1;
    expect_write(32'h10221867);
    set_bundle(2'b00, 6'h04, 5'd1, 5'd2, 5'd3, 11'h067, 22'h0, 26'h0);
    send();
    @(negedge clk);
    check("r_imem_we", 32'(imem_we), 32'd1);
    check("r_imem_addr", 32'(imem_addr), 32'd0);
    check("r_imem_wdata", imem_wdata, 32'h10221867);
    tick();
    @(negedge clk);
    check("r_word_count", 32'(word_count), 32'd1);

    // Table: one bundle per fresh load.
    for (int i = 0; i < 7; i++) begin
      do_start();
      imem_ready = 1'b1;
      if (vecs[i].wr) expect_write(vecs[i].word);
      set_bundle(vecs[i].fmt, vecs[i].op, vecs[i].ra1, vecs[i].ra2, vecs[i].sh,
                 vecs[i].ext, vecs[i].imm, vecs[i].off);
      send();
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_count", i), 32'(word_count), 32'(vecs[i].wr));
    end

    // Back-to-back bundles at full throughput.
    do_start();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_write(32'h08000010 + 32'(i));
      set_bundle(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 11'h0, 22'h0, 26'h10 + 26'(i));
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_count_mid", 32'(word_count), 32'd2);
    check("b2b_addr_mid", 32'(imem_addr), 32'd2);
    tick();
    @(negedge clk);
    check("b2b_count_end", 32'(word_count), 32'd3);

    // Backpressure: J word held for 4 cycles.
    do_start();
    imem_ready = 1'b0;
    expect_write(32'h0813B067);
    set_bundle(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 11'h0, 22'h0, 26'h13B067);
    send();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_imem_we", 32'(imem_we), 32'd1);
      check("bp_imem_wdata", imem_wdata, 32'h0813B067);
      check("bp_imem_addr", 32'(imem_addr), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_count", 32'(word_count), 32'd0);
    end
    tick();
    imem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_count_after", 32'(word_count), 32'd1);
    check("bp_imem_we_after", 32'(imem_we), 32'd0);

    // Immediate overflow, then a reserved format.
    do_start();
    imem_ready = 1'b1;
    expect_write(32'h14E00000);
    set_bundle(2'b01, 6'h05, 5'd7, 5'd0, 5'd0, 11'h0, 22'h200000, 26'h0);
    send();
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    set_bundle(2'b11, 6'h07, 5'd1, 5'd1, 5'd1, 11'h1, 22'h1, 26'h1);
    send();
    @(negedge clk);
    check("rsv_imem_we", 32'(imem_we), 32'd0);
    check("rsv_count", 32'(word_count), 32'd1);
    check("rsv_err", 32'(err), 32'd1);
    tick();
    @(negedge clk);
    check("rsv_count_later", 32'(word_count), 32'd1);

    // Fill to DEPTH, then restart.
    do_start();
    imem_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expect_write(32'h08000000 + 32'(i));
      set_bundle(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 11'h0, 22'h0, 26'(i));
      send();
    end
    expect_write(32'h04300000);
    set_bundle(2'b01, 6'h01, 5'd1, 5'd0, 5'd0, 11'h0, 22'h100000, 26'h0);
    send();
    tick();
    in_valid = 1'b1;
    @(negedge clk);
    check("full_flag", 32'(full), 32'd1);
    check("full_loading", 32'(loading), 32'd0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(word_count), 32'd4);
    check("full_err", 32'(err), 32'd1);
    check("full_addr_no_wrap", 32'(imem_addr), 32'd3);
    check("full_imem_we", 32'(imem_we), 32'd0);
    in_valid = 1'b0;
    tick();
    do_start();
    @(negedge clk);
    check("restart_loading", 32'(loading), 32'd1);
    check("restart_full", 32'(full), 32'd0);
    check("restart_count", 32'(word_count), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    check("restart_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset with a write in flight.
    tick();
    do_start();
    imem_ready = 1'b0;
    expect_write(32'h10221867);
    set_bundle(2'b00, 6'h04, 5'd1, 5'd2, 5'd3, 11'h067, 22'h0, 26'h0);
    send();
    @(negedge clk);
    check("arst_pre_imem_we", 32'(imem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_imem_we", 32'(imem_we), 32'd0);
    check("arst_loading", 32'(loading), 32'd0);
    check("arst_count", 32'(word_count), 32'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("arst_state_idle", 32'(state), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
